// File: rtl/regfile_mp.sv
// Two-read / one-write register file with optional hardwired zero register,
// optional write-to-read forwarding and a one-register-per-cycle sweep-clear.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             wr_drop_q, wr_drop_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             sweep_en;

  // Writes land only in IDLE; address 0 is silently ignored when hardwired.
  assign wr_en    = we && (state_q == IDLE) && !((ZERO_REG != 0) && (waddr == '0));
  assign sweep_en = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        wr_drop_d = we;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The sweep slot and a write can never coincide: writes require IDLE.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (sweep_en && (cnt_q == AW'(gi))) begin
          mem_q[gi] <= '0;
        end else if (wr_en && (waddr == AW'(gi))) begin
          mem_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    rdata_a = mem_q[raddr_a];
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      rdata_a = '0;
    end else if ((BYPASS != 0) && wr_en && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = mem_q[raddr_b];
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      rdata_b = '0;
    end else if ((BYPASS != 0) && wr_en && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vectors, sweep/reset sequences
// and randomized traffic against an array-based reference model.
module tb_regfile_mp;
  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, we, clr_req;
  logic [AW-1:0] waddr, raddr_a, raddr_b;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
  logic          busy, wr_drop, nb_busy, nb_wr_drop;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
  );

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b),
    .clr_req(clr_req), .busy(nb_busy), .wr_drop(nb_wr_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents, whether a sweep is in progress, how many
  // registers the sweep has already zeroed, and the pending drop flag.
  logic [W-1:0] mdl [D];
  bit           m_sweeping;
  int           m_swept;
  bit           m_drop;

  function automatic logic [W-1:0] mread(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && !m_sweeping && we && (waddr == a)) return wdata;
    return mdl[a];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < D; i++) mdl[i] = '0;
      m_sweeping = 0;
      m_swept    = 0;
      m_drop     = 0;
    end else if (!m_sweeping) begin
      m_drop = 0;
      if (we && waddr != '0) mdl[waddr] = wdata;
      if (clr_req) begin
        m_sweeping = 1;
        m_swept    = 0;
      end
    end else begin
      m_drop = we;
      mdl[m_swept] = '0;
      m_swept++;
      if (m_swept == D) m_sweeping = 0;
    end
  endtask

  // Inputs are set at posedge+1; outputs are compared at posedge+3.
  task automatic tick(input bit do_chk);
    #2;
    if (do_chk) begin
      chk("rdata_a", rdata_a, mread(raddr_a, 1));
      chk("rdata_b", rdata_b, mread(raddr_b, 1));
      chk("nb_rdata_a", nb_rdata_a, mread(raddr_a, 0));
      chk("busy", W'(busy), W'(m_sweeping));
      chk("wr_drop", W'(wr_drop), W'(m_drop));
      chk("nb_busy", W'(nb_busy), W'(m_sweeping));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; clr_req = 0; waddr = '0; wdata = '0;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic [W-1:0]  enb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int k;
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 32'h0,        32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

    idle();
    raddr_a = '0; raddr_b = '0;
    rst = 1;
    tick(0);
    tick(0);
    rst = 0;
    raddr_a = 5'd5; raddr_b = 5'd31;
    #1;
    chk("reset_busy", W'(busy), '0);
    chk("reset_wr_drop", W'(wr_drop), '0);
    chk("reset_rdata_a", rdata_a, '0);
    chk("reset_rdata_b", rdata_b, '0);
    tick(1);

    for (int i = 0; i < 6; i++) begin
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      raddr_a = vecs[i].ra; raddr_b = vecs[i].rb;
      #1;
      $display("[TB] vec %0d we=%0d wa=%0d wd=%h ra=%0d rb=%0d a=%h b=%h", i,
               vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, rdata_a, rdata_b);
      chk("vec_rdata_a", rdata_a, vecs[i].ea);
      chk("vec_rdata_b", rdata_b, vecs[i].eb);
      chk("vec_nb_rdata_a", nb_rdata_a, vecs[i].enb);
      chk("vec_wr_drop", W'(wr_drop), '0);
      tick(1);
    end

    // Sweep with a rejected write in the 3rd clear cycle and an ignored clr_req.
    idle();
    for (int i = 1; i < D; i++) begin
      we = 1; waddr = i[AW-1:0]; wdata = 32'h1000_0000 + i * 32'h0101;
      raddr_a = i[AW-1:0]; raddr_b = 5'd1;
      tick(1);
    end
    idle();
    clr_req = 1;
    tick(1);
    clr_req = 0;
    k = 0;
    while (busy && k < 100) begin
      we = (k == 2); waddr = 5'd9; wdata = 32'h55; clr_req = (k == 5);
      raddr_a = 5'd9; raddr_b = k[AW-1:0];
      #1;
      chk("sweep_wr_drop", W'(wr_drop), (k == 3) ? 32'd1 : 32'd0);
      tick(1);
      k++;
    end
    $display("[TB] sweep busy for %0d cycles", k);
    chk("sweep_len", W'(k), 32'd32);
    idle();
    for (int i = 0; i < D; i++) begin
      raddr_a = i[AW-1:0]; raddr_b = 5'(D - 1 - i);
      #1;
      chk("post_sweep_a", rdata_a, '0);
      chk("post_sweep_b", rdata_b, '0);
      tick(1);
    end

    // Reset in the 10th clear cycle.
    for (int i = 1; i < 5; i++) begin
      we = 1; waddr = i[AW-1:0]; wdata = 32'hCAFE_0000 + i;
      tick(1);
    end
    idle();
    clr_req = 1;
    tick(1);
    clr_req = 0;
    k = 0;
    while (busy && k < 9) begin
      tick(1);
      k++;
    end
    chk("rst_mid_reached", W'(k), 32'd9);
    rst = 1; clr_req = 1; we = 1; waddr = 5'd4; wdata = 32'h77;
    tick(1);
    idle();
    #1;
    chk("busy_after_rst", W'(busy), '0);
    for (int i = 0; i < D; i++) begin
      raddr_a = i[AW-1:0]; raddr_b = i[AW-1:0];
      #1;
      chk("after_rst_a", rdata_a, '0);
      tick(1);
    end
    we = 1; waddr = 5'd3; wdata = 32'hC0FFEE01;
    tick(1);
    idle();
    raddr_a = 5'd3;
    #1;
    chk("write_after_rst", rdata_a, 32'hC0FFEE01);
    $display("[TB] reset mid-sweep sequence done, reg3=%h", rdata_a);
    tick(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clr_req = ($urandom_range(0, 39) == 0);
      we      = $urandom_range(0, 1) != 0;
      waddr   = AW'($urandom_range(0, D - 1));
      wdata   = $urandom;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, D - 1));
      raddr_b = AW'($urandom_range(0, D - 1));
      tick(1);
    end
    idle();
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register.
REQ-002 SHALL have parameter DEPTH, default 32, register count; power of 2, >= 2; AW = log2(DEPTH).
REQ-003 SHALL have parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1, when 1 a same-cycle write is forwarded to the read ports.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  AW  write address.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port raddr_a  input  AW  read address, port A.
REQ-011 SHALL have port raddr_b  input  AW  read address, port B.
REQ-012 SHALL have port rdata_a  output  WIDTH  read data, port A, combinational.
REQ-013 SHALL have port rdata_b  output  WIDTH  read data, port B, combinational.
REQ-014 SHALL have port clr_req  input  1  request to sweep-clear all registers.
REQ-015 SHALL have port busy  output  1  high while a sweep-clear runs.
REQ-016 SHALL have port wr_drop  output  1  registered one-cycle flag: a write was rejected.

Function
REQ-017 SHALL accept a write at the rising edge when we=1 and state=IDLE, storing wdata into register waddr.
REQ-018 SHALL ignore writes to address 0 when ZERO_REG=1; wr_drop stays 0 for this case.
REQ-019 SHALL drive rdata_x = register[raddr_x], or 0 when raddr_x=0 and ZERO_REG=1.
REQ-020 SHALL, when BYPASS=1, we=1, state=IDLE, waddr=raddr_x and the write is not suppressed by REQ-018, drive rdata_x = wdata in the same cycle.
REQ-021 SHALL, when BYPASS=0, return the old contents on a same-cycle read-write collision; the new value is visible the next cycle.
REQ-022 SHALL implement the FSM states IDLE and CLEAR.
REQ-023 SHALL transition IDLE->CLEAR at the edge where clr_req=1; the counter is loaded with 0 and busy=1 from that edge on.
REQ-024 SHALL, in CLEAR, zero register[counter] at each edge and increment the counter.
REQ-025 SHALL, at the edge where counter=DEPTH-1, zero the last register, return to IDLE and deassert busy; the sweep lasts exactly DEPTH cycles.
REQ-026 SHALL, for simultaneous we=1 and clr_req=1 in IDLE, perform the write and also start the sweep; the written value is later cleared.
REQ-027 SHALL ignore clr_req while in CLEAR; it does not restart the sweep.
REQ-028 SHALL, in CLEAR, discard we=1, set wr_drop=1 at the following edge, and disable bypass.
REQ-029 SHALL keep reads functional during CLEAR; reads return current array contents, partially cleared.
REQ-030 SHALL generate a counter of width AW that never wraps past DEPTH-1 within a sweep.

Reset
REQ-031 SHALL, at a rising edge with rst=1, zero all registers, enter IDLE, and clear the counter, busy and wr_drop to 0.
REQ-032 SHALL give rst priority over we and clr_req, including mid-sweep; after the reset, state=IDLE and busy=0 on the next cycle.

Verification
REQ-033 SHALL verify write/read: we=1, waddr=5, wdata=0xDEADBEEF; the next cycle raddr_a=5 -> rdata_a=0xDEADBEEF.
REQ-034 SHALL verify the zero register: with ZERO_REG=1, write 0x1234 to address 0, then raddr_b=0 -> rdata_b=0 and wr_drop=0.
REQ-035 SHALL verify bypass: with BYPASS=1, we=1, waddr=raddr_a=7, wdata=0xA5A5A5A5 -> rdata_a=0xA5A5A5A5 in the same cycle; with BYPASS=0, the old value is returned.
REQ-036 SHALL verify the sweep: fill registers 1..31 with nonzero values, pulse clr_req -> busy high for exactly 32 cycles; afterwards every address reads 0.
REQ-037 SHALL verify a write during sweep: in the 3rd CLEAR cycle, we=1, waddr=9, wdata=0x55 -> wr_drop=1 for one cycle; register 9 reads 0 after the sweep.
REQ-038 SHALL verify reset mid-sweep: rst=1 at the 10th CLEAR cycle -> busy=0 on the next cycle and all registers read 0; a subsequent write to address 3 succeeds.
